airlock_request_scheduler: RTL

- Upstream of the airlock system interface: captures operator arrival/departure button requests and queues them in a small FIFO.
- Issues one-cycle startArrival/startDeparture pulses only when neither workflow is busy.
- Tracks each issued request through acknowledge (busy rises) and completion (busy falls); flags a sticky error if a start is never acknowledged.

---
 rtl/airlock_request_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/airlock_request_scheduler.sv
// Airlock request scheduler: edge-detects operator buttons, queues requests, and issues
// start pulses while tracking acknowledge/completion. Optional macro: AIRLOCK_REQ_DEDUP_EN.
module airlock_request_scheduler #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned ACK_TIMEOUT = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     reqArrival,
   input  logic                     reqDeparture,
   input  logic                     arrivalBusy,
   input  logic                     departureBusy,
   output logic                     startArrival,
   output logic                     startDeparture,
   output logic [$clog2(DEPTH):0]   queueCount,
   output logic                     queueFull,
   output logic                     dropped,
   output logic                     timeoutError
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StRun} stateT;

   stateT            stateQ, stateD;
   logic             prevArrival, prevDeparture;
   logic [DEPTH-1:0] fifoMem;
   logic [PtrW-1:0]  rdPtr, wrPtr;
   logic [CntW-1:0]  count;
   logic             curTypeQ, curTypeD;
   logic [7:0]       ackCntQ, ackCntD;
   logic             timeoutQ, timeoutD;
   logic             droppedQ;

   logic             arrEdge, depEdge, doPop;
   logic             arrDup, depDup, arrPush, depPush, dropNext;
   logic [CntW-1:0]  remain, freeSlots;
   logic             matchBusy;

   assign arrEdge   = reqArrival & ~prevArrival;
   assign depEdge   = reqDeparture & ~prevDeparture;
   assign doPop     = (stateQ == StIdle) && (count != '0) && !arrivalBusy && !departureBusy;
   // A same-cycle pop frees its slot before pushes are judged.
   assign remain    = count - CntW'(doPop);
   assign freeSlots = CntW'(DEPTH) - remain;

`ifdef AIRLOCK_REQ_DEDUP_EN
   logic lastType;
   assign lastType = fifoMem[wrPtr - PtrW'(1)];
   assign arrDup   = arrEdge && (remain != '0) && !lastType;
   // An arrival pushed this cycle becomes the newest entry, so departure cannot match it.
   assign depDup   = depEdge && !arrPush && (remain != '0) && lastType;
`else
   assign arrDup   = 1'b0;
   assign depDup   = 1'b0;
`endif

   assign arrPush  = arrEdge && !arrDup && (freeSlots != '0);
   assign depPush  = depEdge && !depDup && (freeSlots > CntW'(arrPush));
   assign dropNext = (arrEdge && !arrDup && !arrPush) || (depEdge && !depDup && !depPush);

   always_ff @(posedge clock) begin
      if (reset) begin
         prevArrival   <= 1'b0;
         prevDeparture <= 1'b0;
         fifoMem       <= '0;
         rdPtr         <= '0;
         wrPtr         <= '0;
         count         <= '0;
         droppedQ      <= 1'b0;
      end else begin
         prevArrival   <= reqArrival;
         prevDeparture <= reqDeparture;
         if (arrPush) fifoMem[wrPtr] <= 1'b0;
         if (depPush) fifoMem[wrPtr + PtrW'(arrPush)] <= 1'b1;
         wrPtr    <= wrPtr + PtrW'(arrPush) + PtrW'(depPush);
         if (doPop) rdPtr <= rdPtr + PtrW'(1);
         count    <= count + CntW'(arrPush) + CntW'(depPush) - CntW'(doPop);
         droppedQ <= dropNext;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stateQ   <= StIdle;
         curTypeQ <= 1'b0;
         ackCntQ  <= '0;
         timeoutQ <= 1'b0;
      end else begin
         stateQ   <= stateD;
         curTypeQ <= curTypeD;
         ackCntQ  <= ackCntD;
         timeoutQ <= timeoutD;
      end
   end

   assign matchBusy = curTypeQ ? departureBusy : arrivalBusy;

   always_comb begin
      stateD         = stateQ;
      curTypeD       = curTypeQ;
      ackCntD        = ackCntQ;
      timeoutD       = timeoutQ;
      startArrival   = 1'b0;
      startDeparture = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (doPop) begin
               curTypeD = fifoMem[rdPtr];
               stateD   = StIssue;
            end
         end
         StIssue: begin
            startArrival   = !curTypeQ;
            startDeparture = curTypeQ;
            ackCntD        = '0;
            stateD         = StWaitAck;
         end
         StWaitAck: begin
            if (matchBusy) begin
               stateD = StRun;
            end else if (ackCntQ == 8'(ACK_TIMEOUT - 1)) begin
               timeoutD = 1'b1;
               stateD   = StIdle;
            end else begin
               ackCntD = ackCntQ + 8'd1;
            end
         end
         StRun: begin
            if (!matchBusy) stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase
   end

   assign queueCount   = count;
   assign queueFull    = (count == CntW'(DEPTH));
   assign dropped      = droppedQ;
   assign timeoutError = timeoutQ;

endmodule
